// File: rtl/ahb_pkg.sv
// Shared AHB encodings, FSM state type and byte-lane helper for the SRAM responder.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << lo;
      HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Byte-enabled word array: one synchronous write port, one asynchronous read port.
module ahb_sram_mem #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [3:0]                   be,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [31:0]                  wdata,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [31:0]                  rdata
);

  logic [31:0] mem_q [MEM_WORDS];

  // Contents deliberately have no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB SRAM responder: pipelined address/data phases, fixed wait states,
// two-cycle ERROR for out-of-range, oversized or misaligned beats.
module ahb_sram_slave import ahb_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_hsel,
  input  logic [31:0] i_haddr,
  input  logic [1:0]  i_htrans,
  input  logic        i_hwrite,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  input  logic [31:0] i_hwdata,
  input  logic        i_hreadyin,
  output logic        o_hready,
  output logic [1:0]  o_hresp,
  output logic [31:0] o_hrdata
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;
  logic            hready_q, hready_d;
  hresp_t          hresp_q, hresp_d;

  htrans_t         trans_s;
  logic [31:0]     off_s;
  logic            aligned_s;
  logic            legal_s;
  logic            accept_s;
  logic            can_accept_s;
  logic [31:0]     rdata_s;
  logic            unused_s;

  assign unused_s = ^i_hburst;
  assign trans_s  = htrans_t'(i_htrans);
  assign off_s    = i_haddr - BASE_ADDR;

  // Natural alignment per transfer size; reserved sizes are never aligned.
  always_comb begin
    case (i_hsize)
      HSIZE_BYTE: aligned_s = 1'b1;
      HSIZE_HALF: aligned_s = ~i_haddr[0];
      HSIZE_WORD: aligned_s = (i_haddr[1:0] == 2'b00);
      default:    aligned_s = 1'b0;
    endcase
  end

  // A new beat may only start when no data phase is still being stretched.
  assign can_accept_s = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign legal_s  = (off_s < MEM_BYTES) && (i_hsize <= HSIZE_WORD) && aligned_s;
  assign accept_s = i_hsel && i_hreadyin && can_accept_s &&
                    ((trans_s == HTRANS_NONSEQ) || (trans_s == HTRANS_SEQ));

  // Next-state, beat latch and registered response computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          idx_d   = off_s[AW+1:2];
          be_d    = byte_en(i_hsize, i_haddr[1:0]);
          write_d = i_hwrite && legal_s;
          if (!legal_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    hready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Reset drops any pending beat, including a write still counting wait states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      be_q     <= 4'b0000;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  ahb_sram_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    ((state_q == ST_DATA) && write_q),
    .be    (be_q),
    .waddr (idx_q),
    .wdata (i_hwdata),
    .raddr (idx_q),
    .rdata (rdata_s)
  );

  assign o_hready = hready_q;
  assign o_hresp  = hresp_q;
  assign o_hrdata = ((state_q == ST_DATA) && !write_q) ? rdata_s : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with 0, 2 and 3 wait states
// share one pipelined AHB driver; each beat's expected response is queued on accept.
module tb_ahb_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] S_B = 3'b000;
  localparam logic [2:0] S_H = 3'b001;
  localparam logic [2:0] S_W = 3'b010;

  typedef struct {
    bit          sel;
    logic [1:0]  tr;
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } beat_t;

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          waits;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  hsel_v;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [2:0]  hready_v;
  logic [1:0]  hresp_v  [3];
  logic [31:0] hrdata_v [3];

  beat_t beats[$];
  exp_t  sb[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(0)) u_d0 (
    .clk(clk), .resetn(resetn), .i_hsel(hsel_v[0]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hreadyin(hready_v[0]), .o_hready(hready_v[0]), .o_hresp(hresp_v[0]), .o_hrdata(hrdata_v[0]));

  ahb_sram_slave #(.WAIT_STATES(2)) u_d2 (
    .clk(clk), .resetn(resetn), .i_hsel(hsel_v[1]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hreadyin(hready_v[1]), .o_hready(hready_v[1]), .o_hresp(hresp_v[1]), .o_hrdata(hrdata_v[1]));

  ahb_sram_slave #(.WAIT_STATES(3)) u_d3 (
    .clk(clk), .resetn(resetn), .i_hsel(hsel_v[2]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst), .i_hwdata(hwdata),
    .i_hreadyin(hready_v[2]), .o_hready(hready_v[2]), .o_hresp(hresp_v[2]), .o_hrdata(hrdata_v[2]));

  task automatic add(input bit sel, input logic [1:0] tr, input bit wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input bit err, input logic [31:0] rd);
    beat_t b;
    b.sel = sel; b.tr = tr; b.wr = wr; b.sz = sz; b.a = a; b.wd = wd; b.err = err; b.rd = rd;
    beats.push_back(b);
  endtask

  task automatic next_addr(input int which, output beat_t cur, output bit have);
    if (beats.size() > 0) begin
      cur    = beats.pop_front();
      hsel_v = cur.sel ? 3'(3'b001 << which) : 3'b000;
      htrans = cur.tr;
      hwrite = cur.wr;
      hsize  = cur.sz;
      haddr  = cur.a;
      have   = 1'b1;
    end else begin
      cur    = '{default: '0};
      hsel_v = 3'b000;
      htrans = T_IDLE;
      hwrite = 1'b0;
      hsize  = S_W;
      haddr  = 32'h0000_0000;
      have   = 1'b0;
    end
  endtask

  // Drives the queued beats through a pipelined bus and scores every data phase.
  task automatic run_seq(input int which, input int ws, input string tag);
    beat_t       cur;
    exp_t        e;
    bit          have;
    logic        hr;
    logic [1:0]  rs;
    logic [31:0] rd;
    int          low, guard, nbeat;
    low = 0; guard = 0; nbeat = 0; have = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    next_addr(which, cur, have);
    while ((have || sb.size() > 0) && guard < 300) begin
      @(negedge clk);
      hr = hready_v[which];
      rs = hresp_v[which];
      rd = hrdata_v[which];
      if (sb.size() > 0) begin
        e = sb[0];
        if (hr === 1'b0) begin
          low++;
          total++;
          if (rs !== (e.err ? 2'b01 : 2'b00)) begin
            bad++;
            $display("FAIL %s beat%0d stall-hresp: got %b want %b", tag, e.id, rs, e.err ? 2'b01 : 2'b00);
          end
        end else begin
          e = sb.pop_front();
          total++;
          if (rs !== (e.err ? 2'b01 : 2'b00)) begin
            bad++;
            $display("FAIL %s beat%0d hresp: got %b want %b", tag, e.id, rs, e.err ? 2'b01 : 2'b00);
          end
          total++;
          if (rd !== e.rdata) begin
            bad++;
            $display("FAIL %s beat%0d hrdata: got %h want %h", tag, e.id, rd, e.rdata);
          end
          total++;
          if (low != e.waits) begin
            bad++;
            $display("FAIL %s beat%0d wait-cycles: got %0d want %0d", tag, e.id, low, e.waits);
          end
          low = 0;
        end
      end
      @(posedge clk); #1;
      if (hr === 1'b1) begin
        if (have) begin
          e.err   = cur.err;
          e.rdata = cur.rd;
          e.waits = (cur.sel && cur.tr[1]) ? (cur.err ? 1 : ws) : 0;
          e.id    = nbeat;
          nbeat++;
          sb.push_back(e);
          hwdata = cur.wr ? cur.wd : 32'h0BAD_F00D;
        end
        next_addr(which, cur, have);
      end
      guard++;
    end
    total++;
    if (guard >= 300) begin
      bad++;
      $display("FAIL %s timeout: got %0d cycles want <300", tag, guard);
    end
    beats.delete();
    sb.delete();
    hsel_v = 3'b000;
    htrans = T_IDLE;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    hsel_v = 3'b000; htrans = T_IDLE; hwrite = 1'b0; hsize = S_W; hburst = 3'b000;
    haddr = 32'h0; hwdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (hready_v[k] !== 1'b1) begin bad++; $display("FAIL reset d%0d hready: got %b want 1", k, hready_v[k]); end
      total++;
      if (hresp_v[k] !== 2'b00) begin bad++; $display("FAIL reset d%0d hresp: got %b want 00", k, hresp_v[k]); end
      total++;
      if (hrdata_v[k] !== 32'h0) begin bad++; $display("FAIL reset d%0d hrdata: got %h want 0", k, hrdata_v[k]); end
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_word_rw();
    add(1, T_NSEQ, 1, S_W, 32'h8000_0000, 32'hF0FF_0FAA, 0, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0000, 32'h0,         0, 32'hF0FF_0FAA);
    run_seq(0, 0, "word_rw");
  endtask

  task automatic test_sub_word();
    add(1, T_NSEQ, 1, S_W, 32'h8000_0004, 32'h0000_0000, 0, 32'h0);
    add(1, T_NSEQ, 1, S_H, 32'h8000_0006, 32'hBEEF_1234, 0, 32'h0);
    add(1, T_NSEQ, 1, S_B, 32'h8000_0004, 32'h1122_335A, 0, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0004, 32'h0,         0, 32'hBEEF_005A);
    add(1, T_NSEQ, 1, S_B, 32'h8000_0005, 32'h0000_C300, 0, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0004, 32'h0,         0, 32'hBEEF_C35A);
    run_seq(0, 0, "sub_word");
  endtask

  task automatic test_wait_states();
    add(1, T_NSEQ, 1, S_W, 32'h8000_0010, 32'hA5A5_0001, 0, 32'h0);
    add(1, T_NSEQ, 1, S_W, 32'h8000_0014, 32'h5A5A_0002, 0, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0010, 32'h0,         0, 32'hA5A5_0001);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0014, 32'h0,         0, 32'h5A5A_0002);
    run_seq(1, 2, "wait2");
  endtask

  task automatic test_illegal();
    add(1, T_NSEQ, 1, S_W, 32'h8000_0000, 32'h1357_9BDF, 0, 32'h0);
    add(1, T_NSEQ, 1, S_W, 32'h8000_0FFC, 32'h0FFC_0FFC, 0, 32'h0);
    add(1, T_NSEQ, 1, S_W, 32'h8000_1000, 32'hCAFE_0001, 1, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_1000, 32'h0,         1, 32'h0);
    add(1, T_NSEQ, 1, S_W, 32'h8000_0002, 32'hCAFE_0002, 1, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0002, 32'h0,         1, 32'h0);
    add(1, T_NSEQ, 1, S_H, 32'h8000_0001, 32'hCAFE_0003, 1, 32'h0);
    add(1, T_NSEQ, 1, 3'b011, 32'h8000_0000, 32'hCAFE_0004, 1, 32'h0);
    add(1, T_NSEQ, 1, S_W, 32'h7FFF_FFFC, 32'hCAFE_0005, 1, 32'h0);
    add(1, T_NSEQ, 1, S_B, 32'h8000_0003, 32'hAB00_0000, 0, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0000, 32'h0,         0, 32'hAB57_9BDF);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0FFC, 32'h0,         0, 32'h0FFC_0FFC);
    run_seq(0, 0, "illegal");
  endtask

  task automatic test_busy_burst();
    add(1, T_NSEQ, 1, S_W, 32'h8000_0030, 32'h3030_3030, 0, 32'h0);
    add(1, T_NSEQ, 1, S_W, 32'h8000_0020, 32'h1111_0001, 0, 32'h0);
    add(1, T_SEQ,  1, S_W, 32'h8000_0024, 32'h2222_0002, 0, 32'h0);
    add(1, T_BUSY, 1, S_W, 32'h8000_0030, 32'hDEAD_DEAD, 0, 32'h0);
    add(1, T_SEQ,  1, S_W, 32'h8000_0028, 32'h3333_0003, 0, 32'h0);
    add(1, T_SEQ,  1, S_W, 32'h8000_002C, 32'h4444_0004, 0, 32'h0);
    add(0, T_NSEQ, 1, S_W, 32'h8000_0020, 32'h9999_9999, 0, 32'h0);
    add(1, T_IDLE, 1, S_W, 32'h8000_0024, 32'h8888_8888, 0, 32'h0);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0020, 32'h0, 0, 32'h1111_0001);
    add(1, T_SEQ,  0, S_W, 32'h8000_0024, 32'h0, 0, 32'h2222_0002);
    add(1, T_SEQ,  0, S_W, 32'h8000_0028, 32'h0, 0, 32'h3333_0003);
    add(1, T_SEQ,  0, S_W, 32'h8000_002C, 32'h0, 0, 32'h4444_0004);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0030, 32'h0, 0, 32'h3030_3030);
    run_seq(0, 0, "busy_burst");
  endtask

  task automatic test_reset_mid();
    add(1, T_NSEQ, 1, S_W, 32'h8000_0040, 32'h0000_00AA, 0, 32'h0);
    run_seq(2, 3, "rst_mid_pre");
    @(posedge clk); #1;
    hsel_v = 3'b100; htrans = T_NSEQ; hwrite = 1'b1; hsize = S_W; haddr = 32'h8000_0040;
    @(posedge clk); #1;
    hsel_v = 3'b000; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'h5555_5555;
    total++;
    if (hready_v[2] !== 1'b0) begin bad++; $display("FAIL rst_mid stall-hready: got %b want 0", hready_v[2]); end
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    total++;
    if (hready_v[2] !== 1'b1) begin bad++; $display("FAIL rst_mid hready: got %b want 1", hready_v[2]); end
    total++;
    if (hresp_v[2] !== 2'b00) begin bad++; $display("FAIL rst_mid hresp: got %b want 00", hresp_v[2]); end
    total++;
    if (hrdata_v[2] !== 32'h0) begin bad++; $display("FAIL rst_mid hrdata: got %h want 0", hrdata_v[2]); end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    add(1, T_NSEQ, 0, S_W, 32'h8000_0040, 32'h0, 0, 32'h0000_00AA);
    run_seq(2, 3, "rst_mid_post");
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_sub_word();
    test_wait_states();
    test_illegal();
    test_busy_burst();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
